// File: rtl/counter_pkg.sv
// Shared constants for the mode-select up/down counter and its input control stage.
package counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP        = 2'd0;
  localparam mode_t MODE_DOWN      = 2'd1;
  localparam mode_t MODE_UP_MOD3   = 2'd2;
  localparam mode_t MODE_DOWN_MOD3 = 2'd3;

  // Short values keep simulation fast; board builds use real button/human timescales.
  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;
  localparam int unsigned AUTO_DIV_SIM          = 8;
  localparam int unsigned DEBOUNCE_CYCLES_BOARD = 500000;
  localparam int unsigned AUTO_DIV_BOARD        = 25000000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-cycle debounce and rising-edge press detect
// for one raw push-button.
module btn_debounce
  import counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q,  sync1_d;
  logic             sync2_q,  sync2_d;
  logic             stable_q, stable_d;
  logic             prev_q,   prev_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Any cycle agreeing with the stable value restarts the count, so glitches never accumulate.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = stable_q & ~prev_q;

endmodule

// File: rtl/counter_input_ctrl.sv
// Turns raw step/mode buttons and the auto-step switch into the counter's
// mode select (s1,s0) and a registered one-cycle step strobe.
module counter_input_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int unsigned AUTO_DIV        = AUTO_DIV_SIM
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_step,
  input  logic btn_mode,
  input  logic auto_en,
  output logic s0,
  output logic s1,
  output logic step
);

  localparam int unsigned PRE_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(AUTO_DIV - 1);

  logic step_stable, step_press;
  logic mode_stable, mode_press;
  logic unused_stable;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_deb (
    .clock  (clock),
    .reset  (reset),
    .raw    (btn_step),
    .stable (step_stable),
    .press  (step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_deb (
    .clock  (clock),
    .reset  (reset),
    .raw    (btn_mode),
    .stable (mode_stable),
    .press  (mode_press)
  );

  assign unused_stable = step_stable ^ mode_stable;

  logic             auto_sync1_q, auto_sync1_d;
  logic             auto_sync2_q, auto_sync2_d;
  logic [PRE_W-1:0] presc_q,      presc_d;
  mode_t            mode_q,       mode_d;
  logic             step_q,       step_d;
  logic             auto_tick_c;

  // Prescaler runs only while the synced switch is on and restarts from zero on re-enable.
  always_comb begin
    auto_sync1_d = auto_en;
    auto_sync2_d = auto_sync1_q;
    presc_d      = '0;
    auto_tick_c  = auto_sync2_q && (presc_q == PRE_MAX);
    if (auto_sync2_q && !auto_tick_c) begin
      presc_d = presc_q + PRE_W'(1);
    end
    mode_d = mode_q + 2'(mode_press);
    step_d = step_press | auto_tick_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      auto_sync1_q <= 1'b0;
      auto_sync2_q <= 1'b0;
      presc_q      <= '0;
      mode_q       <= MODE_UP;
      step_q       <= 1'b0;
    end else begin
      auto_sync1_q <= auto_sync1_d;
      auto_sync2_q <= auto_sync2_d;
      presc_q      <= presc_d;
      mode_q       <= mode_d;
      step_q       <= step_d;
    end
  end

  assign s0   = mode_q[0];
  assign s1   = mode_q[1];
  assign step = step_q;

endmodule
